satalnk_rxcrc: RTL
==================

SATALNK_RXCRC -- requirements
Module: satalnk_rxcrc

Interface
REQ-001 SHALL have parameter MAXLEN, default 2049: maximum FIS length in 32-bit words, excluding the CRC word.
REQ-002 SHALL have parameter CRC_INIT, default 32'h52325032: CRC seed at start of every frame.
REQ-003 SHALL have ports as follows; reset i_reset, synchronous, active-low; clock i_phy_clk:
- i_phy_clk  in  1  receive clock
- i_reset  in  1  synchronous reset, active low
- i_valid  in  1  descrambled frame word present; no backpressure
- i_data  in  32  frame word
- i_last  in  1  marks the CRC word, the final word of the frame
- i_abort  in  1  link abandoned the frame (SYNC escape / R_ERR)
- o_valid  out  1  payload word valid
- o_data  out  32  payload word
- o_last  out  1  final payload word of a CRC-good frame
- o_link_err  out  1  one-cycle pulse: current frame is bad and has been dropped downstream
- o_err_count  out  16  saturating count of bad frames

Function
REQ-004 SHALL compute the SATA CRC: polynomial 32'h04C11DB7, non-reflected, MSB-first over each 32-bit word, one word per clock, no final XOR.
REQ-005 SHALL seed the CRC with CRC_INIT when the first word of a frame is accepted; the CRC SHALL cover every word except the one with i_last.
REQ-006 SHALL implement states IDLE, FIRST, DATA, DISCARD.
- IDLE: waiting for a frame.
- FIRST: one word buffered, nothing emitted.
- DATA: one word buffered, earlier words emitted.
- DISCARD: dropping words until i_last.
REQ-007 SHALL hold exactly one buffered word. Each non-last i_valid word in FIRST/DATA SHALL push the buffer out as o_valid=1, o_last=0 on the next cycle, then replace it.
- Latency: payload word n appears one cycle after word n+1 is accepted.
REQ-008 SHALL compare i_data against the running CRC when i_valid && i_last occurs in FIRST or DATA.
- Match: on the next cycle, emit the buffered word with o_valid=1, o_last=1; go to IDLE.
- Mismatch: on the next cycle, o_valid=0, o_link_err=1; go to IDLE.
REQ-009 SHALL treat i_valid && i_last in IDLE (frame with only a CRC word, no payload) as an error: o_link_err=1 next cycle, no o_valid.
REQ-010 SHALL keep a 12-bit payload word counter. When a non-last word would make the count exceed MAXLEN:
- pulse o_link_err; emit no further o_valid; enter DISCARD.
- DISCARD exits to IDLE on i_valid && i_last, with no second o_link_err.
REQ-011 SHALL respond to i_abort in FIRST, DATA or DISCARD by returning to IDLE and discarding the buffer.
- o_link_err=1 next cycle, except from DISCARD, where no pulse is generated.
- i_abort in IDLE SHALL be ignored.
- i_abort SHALL take priority over a simultaneous i_valid.
REQ-012 SHALL register o_valid, o_data, o_last and o_link_err; o_valid and o_link_err SHALL never be high in the same cycle.
REQ-013 SHALL increment o_err_count on every o_link_err pulse, saturating at 16'hFFFF.
REQ-014 SHALL keep o_last low whenever o_valid is low; o_data is don't-care when o_valid=0.
REQ-015 SHALL start a new frame on a word arriving in IDLE in the cycle after a frame ends; back-to-back frames are required.

Reset
REQ-016 SHALL, while i_reset=0 at a rising i_phy_clk edge, force the following on the next cycle:
- state IDLE, word counter 0, CRC register = CRC_INIT
- o_valid=0, o_last=0, o_link_err=0, o_err_count=0, o_data=0
REQ-017 SHALL abandon a frame in progress when reset asserts mid-frame, with no o_last and no o_link_err. The first i_valid after reset deasserts SHALL be treated as word 0 of a new frame.

Verification
REQ-018 Good frame: words 32'h00000034, 32'h11223344, 32'h55667788, then the golden-model CRC with i_last -> o_valid for exactly 3 words in order, o_last on 32'h55667788, o_link_err never, o_err_count=0.
REQ-019 Corrupt CRC: same frame, CRC word XOR 32'h1 -> 2 words out with o_last never set; o_link_err pulses once on the cycle the third word would have appeared; o_err_count=1.
REQ-020 Overlength: MAXLEN=4, frame of 6 payload words plus CRC -> 3 words out, one o_link_err after word 5 is accepted, no o_valid again until the next frame.
REQ-021 Abort and back-to-back: i_abort after word 2 of a frame, then an immediate good 1-payload-word frame -> one o_link_err, then a single o_valid && o_last carrying the new payload word.
REQ-022 Reset mid-frame, then CRC-only frame: i_reset=0 for one cycle after word 1 -> no outputs; a following frame consisting only of an i_last word -> o_link_err=1 and o_err_count=1.

Source files
------------

// File: rtl/satalnk_rxcrc.sv
// SATA link-layer receive CRC checker: holds back one word so the final payload
// word can be flagged o_last only once the trailing CRC word has been checked.
//
// state   | meaning
// IDLE    | waiting for the first word of a frame
// FIRST   | one word held, nothing emitted yet
// DATA    | one word held, earlier words emitted
// DISCARD | frame too long, dropping words until i_last
module satalnk_rxcrc #(
  parameter int          MAXLEN   = 2049,
  parameter logic [31:0] CRC_INIT = 32'h52325032
) (
  input  logic        i_phy_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_last,
  input  logic        i_abort,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_last,
  output logic        o_link_err,
  output logic [15:0] o_err_count
);
  localparam logic [31:0] POLY     = 32'h04C11DB7;
  localparam logic [11:0] MAXLEN_W = 12'(MAXLEN);

  typedef enum logic [1:0] {IDLE, FIRST, DATA, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [31:0] hold_q, crc_q, crc_next;
  logic [11:0] cnt_q;
  logic        in_frame, word_in, crc_in, over, crc_ok;
  logic        take_first, take_more;
  logic        emit, emit_last, err;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
    end
    return r;
  endfunction

  assign in_frame   = (state == FIRST) || (state == DATA);
  assign word_in    = i_valid && !i_last;
  assign crc_in     = i_valid && i_last;
  // a further word would push the count past MAXLEN
  assign over       = (cnt_q >= MAXLEN_W);
  assign crc_ok     = (i_data == crc_q);
  assign take_first = (state == IDLE) && word_in;
  assign take_more  = in_frame && !i_abort && word_in && !over;
  assign crc_next   = crc_step(take_first ? CRC_INIT : crc_q, i_data);

  always_ff @(posedge i_phy_clk) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (word_in) state_nxt = FIRST;
      end
      FIRST, DATA: begin
        if (i_abort)      state_nxt = IDLE;
        else if (crc_in)  state_nxt = IDLE;
        else if (word_in) state_nxt = over ? DISCARD : DATA;
      end
      DISCARD: begin
        if (i_abort || crc_in) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    emit      = 1'b0;
    emit_last = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        err = crc_in;
      end
      FIRST, DATA: begin
        if (i_abort) begin
          err = 1'b1;
        end else if (crc_in) begin
          emit      = crc_ok;
          emit_last = crc_ok;
          err       = !crc_ok;
        end else if (word_in) begin
          emit = !over;
          err  = over;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_phy_clk) begin
    if (!i_reset) begin
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_link_err  <= 1'b0;
      o_data      <= '0;
      o_err_count <= '0;
      hold_q      <= '0;
      crc_q       <= CRC_INIT;
      cnt_q       <= '0;
    end else begin
      o_valid    <= emit;
      o_last     <= emit_last;
      o_link_err <= err;
      if (emit) o_data <= hold_q;
      if (err && (o_err_count != 16'hFFFF)) o_err_count <= o_err_count + 16'd1;
      if (take_first || take_more) begin
        hold_q <= i_data;
        crc_q  <= crc_next;
        cnt_q  <= take_first ? 12'd1 : cnt_q + 12'd1;
      end else if (state_nxt == IDLE) begin
        crc_q <= CRC_INIT;
        cnt_q <= '0;
      end
    end
  end

endmodule
